// File: rtl/adc_spi_reader_if.sv
// rtl/adc_spi_reader_if.sv - read request/response bundle for adc_spi_reader
//
// Signals:
//   rd_req   : read request, taken only while busy=0 and the reader is idle
//   rd_addr  : register address, latched when the request is accepted
//   busy     : a frame is in progress
//   rd_valid : one-cycle pulse, rd_data holds a fresh value
//   rd_data  : captured register value, held until the next rd_valid
// Modports: master (requester side), slave (adc_spi_reader side).

interface adc_spi_reader_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  busy;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  busy,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output busy,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/adc_spi_reader.sv
// rtl/adc_spi_reader.sv - serial read master for the ADC configuration port
//
// Runs one frame {1'b1, addr, DATA_WIDTH zeros}, MSB first, and captures the
// last DATA_WIDTH bits returned on adc_sdout_in.
//
// Ports:
//   clk           : system clock
//   rst           : synchronous active-high reset
//   rd            : request/response bundle (adc_spi_reader_if.slave)
//   adc_sen_out   : serial enable, active-low
//   adc_sclk_out  : serial clock, idles low
//   adc_sdata_out : serial data to the ADC
//   adc_sdout_in  : serial read data from the ADC
//
// Optional feature macro: ADC_SPI_RD_SYNC_EN
//   Defined: adc_sdout_in goes through a 2-flop synchronizer and is sampled in
//   the (CLK_DIV-1)-th cycle of the SCLK high half (needs CLK_DIV >= 3).
//   Undefined: adc_sdout_in is sampled directly in the last high-half cycle.

module adc_spi_reader #(
    parameter int CLK_DIV    = 4,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    adc_spi_reader_if.slave    rd,
    output logic               adc_sen_out,
    output logic               adc_sclk_out,
    output logic               adc_sdata_out,
    input  logic               adc_sdout_in
);
    localparam int N     = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(N);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(N - 1);
    localparam logic [BIT_W-1:0] BIT_DATA0  = BIT_W'(1 + ADDR_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [N-1:0]          sh_q, sh_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sen_q, sen_d;
    logic                  sclk_q, sclk_d;
    logic                  sdata_q, sdata_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic                  sdo;

`ifdef ADC_SPI_RD_SYNC_EN
    // Two cycles of synchronizer delay: sampling one cycle earlier still sees
    // the bit the ADC drove before the falling edge.
    localparam logic [DIV_W-1:0] SAMPLE_AT = DIV_W'(CLK_DIV - 2);
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], adc_sdout_in};
    end
    assign sdo = sync_q[1];
`else
    localparam logic [DIV_W-1:0] SAMPLE_AT = DIV_LAST;
    assign sdo = adc_sdout_in;
`endif

    wire div_last = (div_q == DIV_LAST);

    // Outputs are computed for the coming cycle and registered, so every
    // pin changes exactly on a clk edge with no input-to-output path.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        cap_d   = cap_q;
        data_d  = data_q;
        sen_d   = 1'b1;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd.rd_req) begin
                    state_d = S_SETUP;
                    sh_d    = {1'b1, rd.rd_addr, {DATA_WIDTH{1'b0}}};
                    div_d   = '0;
                    bit_d   = '0;
                    sen_d   = 1'b0;
                    busy_d  = 1'b1;
                    sdata_d = 1'b1;
                end
            end
            S_SETUP: begin
                sen_d   = 1'b0;
                busy_d  = 1'b1;
                sdata_d = sh_q[N-1];
                div_d   = div_q + 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sen_d   = 1'b0;
                busy_d  = 1'b1;
                sclk_d  = sclk_q;
                sdata_d = sdata_q;
                div_d   = div_q + 1'b1;
                if (sclk_q && div_q == SAMPLE_AT && bit_q >= BIT_DATA0)
                    cap_d = {cap_q[DATA_WIDTH-2:0], sdo};
                if (div_last) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_HOLD;
                            sdata_d = 1'b0;
                        end else begin
                            // Data only moves at the SCLK falling edge.
                            bit_d   = bit_q + 1'b1;
                            sh_d    = sh_q << 1;
                            sdata_d = sh_q[N-2];
                        end
                    end
                end
            end
            S_HOLD: begin
                sen_d  = 1'b0;
                busy_d = 1'b1;
                div_d  = div_q + 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    state_d = S_DONE;
                    sen_d   = 1'b1;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    data_d  = cap_q;
                end
            end
            S_DONE: begin
                // Request is not taken here; acceptance happens in IDLE only.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            cap_q   <= '0;
            data_q  <= '0;
            sen_q   <= 1'b1;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            sen_q   <= sen_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign adc_sen_out   = sen_q;
    assign adc_sclk_out  = sclk_q;
    assign adc_sdata_out = sdata_q;
    assign rd.busy       = busy_q;
    assign rd.rd_valid   = valid_q;
    assign rd.rd_data    = data_q;
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb/tb_adc_spi_reader.sv - self-checking bench for adc_spi_reader
module tb_adc_spi_reader;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int N  = 1 + AW + DW;
    localparam int CD = 4;
    localparam int L  = 1 + (2 * N + 2) * CD;
`ifdef ADC_SPI_RD_SYNC_EN
    localparam int  CD1   = 3;
    localparam int  LAT1  = 103;
    localparam time GAP1  = 60;
`else
    localparam int  CD1   = 1;
    localparam int  LAT1  = 35;
    localparam time GAP1  = 20;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_spi_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifm ();
    adc_spi_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

    logic sen, sclk, sdata, sdout;
    logic sen1, sclk1, sdata1, sdout1;

    adc_spi_reader #(.CLK_DIV(CD), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .rd(ifm),
        .adc_sen_out(sen), .adc_sclk_out(sclk), .adc_sdata_out(sdata), .adc_sdout_in(sdout)
    );
    adc_spi_reader #(.CLK_DIV(CD1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut1 (
        .clk(clk), .rst(rst), .rd(if1),
        .adc_sen_out(sen1), .adc_sclk_out(sclk1), .adc_sdata_out(sdata1), .adc_sdout_in(sdout1)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // ADC register map seen by the main reader.
    logic [7:0] mem [128];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[7'h3F] = 8'hA5;
        mem[7'h01] = 8'h12;
        mem[7'h02] = 8'h34;
        mem[7'h05] = 8'hFF;
        mem[7'h10] = 8'h5A;
    end

    // ADC model: decodes the address from the frame and drives the data bits
    // after each SCLK falling edge; drives 1 outside the data phase.
    logic [15:0] rx;
    int          rises;
    logic [7:0]  a_val;
    initial sdout = 1'b1;
    always @(negedge sen) begin rises = 0; sdout = 1'b1; end
    always @(posedge sclk) if (sen === 1'b0) begin rx = {rx[14:0], sdata}; rises++; end
    always @(negedge sclk) if (sen === 1'b0) begin
        if (rises == AW + 1) a_val = mem[rx[6:0]];
        if (rises >= AW + 1 && rises < N) sdout = a_val[N - 1 - rises];
        else sdout = 1'b1;
    end

    // Second ADC model for the fast-divider reader: fixed value 0x81.
    logic [7:0] val1 = 8'h81;
    int         rises1;
    time        last1;
    bit         gap_bad1 = 1'b0;
    initial sdout1 = 1'b1;
    always @(negedge sen1) begin rises1 = 0; last1 = 0; sdout1 = 1'b1; end
    always @(posedge sclk1) if (sen1 === 1'b0) begin
        if (last1 != 0 && ($time - last1) != GAP1) gap_bad1 = 1'b1;
        last1 = $time;
        rises1++;
    end
    always @(negedge sclk1) if (sen1 === 1'b0) begin
        if (rises1 >= AW + 1 && rises1 < N) sdout1 = val1[N - 1 - rises1];
        else sdout1 = 1'b1;
    end

    int vcount = 0;
    always @(negedge clk) if (ifm.rd_valid === 1'b1) vcount++;

    // Behavioural model of the main reader: ph is the number of cycles since
    // acceptance (0 = idle), L is the DONE cycle.
    int         ph = 0;
    logic [6:0] m_addr = '0;
    logic [7:0] m_data = '0;
    always @(posedge clk) begin
        if (rst) begin
            ph = 0;
            m_data = '0;
        end else if (ph == 0) begin
            if (ifm.rd_req) begin ph = 1; m_addr = ifm.rd_addr; end
        end else if (ph == L - 1) begin
            ph = L;
            m_data = mem[m_addr];
        end else if (ph == L) begin
            ph = 0;
        end else begin
            ph++;
        end
    end

    always @(negedge clk) if (chk_en) begin
        logic        e_busy, e_sclk, e_sdata;
        logic [15:0] frame;
        int          u;
        e_busy  = (ph >= 1 && ph <= L - 1);
        e_sclk  = 1'b0;
        e_sdata = 1'b0;
        frame   = {1'b1, m_addr, 8'h00};
        u       = ph - 1 - CD;
        if (e_busy) begin
            if (ph - 1 < CD) e_sdata = frame[N-1];
            else if (u < 2 * N * CD) begin
                e_sclk  = (u % (2 * CD)) >= CD;
                e_sdata = frame[N - 1 - u / (2 * CD)];
            end
        end
        chk("busy",     32'(ifm.busy),     32'(e_busy));
        chk("rd_valid", 32'(ifm.rd_valid), 32'(ph == L));
        chk("rd_data",  32'(ifm.rd_data),  32'(m_data));
        chk("sen",      32'(sen),          32'(!e_busy));
        chk("sclk",     32'(sclk),         32'(e_sclk));
        chk("sdata",    32'(sdata),        32'(e_sdata));
    end

    task automatic req(input logic [6:0] a, output int t);
        @(negedge clk);
        ifm.rd_req = 1'b1; ifm.rd_addr = a; t = cyc;
        @(negedge clk);
        ifm.rd_req = 1'b0;
    endtask

    task automatic wait_valid(input bit which, input int maxc, output int vc);
        vc = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if ((which ? if1.rd_valid : ifm.rd_valid) === 1'b1) begin vc = cyc; break; end
        end
        if (vc < 0) chk("rd_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t, v1, v2, vc0;
        rst = 1'b1;
        ifm.rd_req = 1'b0; ifm.rd_addr = '0;
        if1.rd_req = 1'b0; if1.rd_addr = '0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_sen",   32'(sen),          32'd1);
        chk("reset_sclk",  32'(sclk),         32'd0);
        chk("reset_sdata", 32'(sdata),        32'd0);
        chk("reset_busy",  32'(ifm.busy),     32'd0);
        chk("reset_valid", 32'(ifm.rd_valid), 32'd0);
        chk("reset_data",  32'(ifm.rd_data),  32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Single read of 0x3F.
        req(7'h3F, t);
        wait_valid(0, 400, v1);
        chk("t1_latency", 32'(v1 - t), 32'd137);
        chk("t1_data",    32'(ifm.rd_data), 32'hA5);
        chk("t1_sclk_rises", 32'(rises), 32'd16);
        chk("t1_sdata_bits", 32'(rx), 32'hBF00);
        repeat (3) @(negedge clk);

        // Back-to-back with rd_req held high; address changed after acceptance.
        @(negedge clk);
        ifm.rd_req = 1'b1; ifm.rd_addr = 7'h01; t = cyc;
        @(negedge clk);
        ifm.rd_addr = 7'h02;
        wait_valid(0, 400, v1);
        chk("b2b_latency", 32'(v1 - t), 32'd137);
        chk("b2b_data1",   32'(ifm.rd_data), 32'h12);
        @(negedge clk);
        @(negedge clk);
        ifm.rd_req = 1'b0;
        wait_valid(0, 400, v2);
        chk("b2b_data2", 32'(ifm.rd_data), 32'h34);
        chk("b2b_gap",   32'(v2 - v1), 32'd138);
        repeat (3) @(negedge clk);

        // Request during a frame is ignored.
        vc0 = vcount;
        req(7'h10, t);
        while (cyc < t + 50) @(negedge clk);
        ifm.rd_req = 1'b1; ifm.rd_addr = 7'h3F;
        @(negedge clk);
        ifm.rd_req = 1'b0;
        wait_valid(0, 400, v1);
        chk("ign_latency", 32'(v1 - t), 32'd137);
        chk("ign_data",    32'(ifm.rd_data), 32'h5A);
        repeat (200) @(negedge clk);
        chk("ign_valid_count", 32'(vcount - vc0), 32'd1);

        // Reset mid-frame.
        req(7'h3F, t);
        while (cyc < t + 70) @(negedge clk);
        rst = 1'b1;
        vc0 = vcount;
        @(negedge clk);
        chk("rst_sen",  32'(sen),         32'd1);
        chk("rst_sclk", 32'(sclk),        32'd0);
        chk("rst_busy", 32'(ifm.busy),    32'd0);
        chk("rst_data", 32'(ifm.rd_data), 32'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("rst_no_valid", 32'(vcount - vc0), 32'd0);
        req(7'h05, t);
        wait_valid(0, 400, v1);
        chk("post_rst_latency", 32'(v1 - t), 32'd137);
        chk("post_rst_data",    32'(ifm.rd_data), 32'hFF);
        repeat (3) @(negedge clk);

        // Fast divider reader.
        @(negedge clk);
        if1.rd_req = 1'b1; if1.rd_addr = 7'h22; t = cyc;
        @(negedge clk);
        if1.rd_req = 1'b0;
        wait_valid(1, 400, v1);
        chk("div1_latency", 32'(v1 - t), 32'(LAT1));
        chk("div1_data",    32'(if1.rd_data), 32'h81);
        chk("div1_rises",   32'(rises1), 32'd16);
        chk("div1_period",  32'(gap_bad1), 32'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
